// File: rtl/data_mem_responder.sv
// Byte-addressed 32-bit data RAM answering RV32 loads/stores over a
// valid/ready request/response handshake, one request in flight.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_write, req_size       store flag, funct3 access size
//   req_addr, req_wdata       byte address, right-aligned store data
//   resp_valid/resp_ready     response handshake
//   resp_rdata, resp_err      extended load data, error flag
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic [31:0] word_q;
    logic [2:0]  size_q;
    logic [1:0]  lane_q;
    logic        err_q;
    logic        write_q;

    logic                  accept;
    logic                  req_err;
    logic [3:0]            be;
    logic [31:0]           wlane;
    logic [ADDR_WIDTH-3:0] widx;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           ext_data;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign widx      = req_addr[ADDR_WIDTH-1:2];

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = |req_addr[1:0];
            3'b100:  req_err = req_write;
            3'b101:  req_err = req_write | req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so the byte enables
    // alone pick which lanes land in the word.
    always_comb begin
        be    = 4'b0000;
        wlane = req_wdata;
        case (req_size)
            3'b000: begin
                be[req_addr[1:0]] = 1'b1;
                wlane = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                be    = req_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{req_wdata[15:0]}};
            end
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (req_err) be = 4'b0000;
    end

    // RAM has no reset; stores commit and loads snapshot the word
    // at the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= mem[widx];
            if (req_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    assign byte_sel = word_q[8*lane_q +: 8];
    assign half_sel = lane_q[1] ? word_q[31:16] : word_q[15:0];

    always_comb begin
        ext_data = 32'h0;
        case (size_q)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  ext_data = word_q;
            3'b100:  ext_data = {24'h0, byte_sel};
            3'b101:  ext_data = {16'h0, half_sel};
            default: ext_data = 32'h0;
        endcase
        if (err_q || write_q) ext_data = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            size_q     <= 3'b000;
            lane_q     <= 2'b00;
            err_q      <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= WAIT;
                        cnt     <= 4'(LATENCY - 1);
                        size_q  <= req_size;
                        lane_q  <= req_addr[1:0];
                        err_q   <= req_err;
                        write_q <= req_write;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ext_data;
                        resp_err   <= err_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed and random loads/stores
// compared against a byte-array memory model.
module tb_data_mem_responder;

    localparam int AW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    int compared = 0;
    int mism     = 0;

    logic [7:0] mem_b [256];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input bit w, input logic [2:0] sz,
                                 input logic [7:0] a);
        case (sz)
            3'd0:    return 1'b0;
            3'd1:    return a[0];
            3'd2:    return a[1:0] != 2'b00;
            3'd4:    return w;
            3'd5:    return w || a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sz,
                                           input logic [7:0] a);
        int    ai;
        int    hb;
        int    wb;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        ai = int'(a);
        hb = ai - (ai % 2);
        wb = ai - (ai % 4);
        b  = mem_b[ai];
        h  = {mem_b[hb+1], mem_b[hb]};
        w  = {mem_b[wb+3], mem_b[wb+2], mem_b[wb+1], mem_b[wb]};
        case (sz)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd2:    return w;
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_store(input logic [2:0] sz, input logic [7:0] a,
                           input logic [31:0] wd);
        int ai;
        ai = int'(a);
        case (sz)
            3'd0: mem_b[ai] = wd[7:0];
            3'd1: begin
                mem_b[ai]   = wd[7:0];
                mem_b[ai+1] = wd[15:8];
            end
            3'd2: for (int i = 0; i < 4; i++) mem_b[ai+i] = wd[8*i +: 8];
            default: ;
        endcase
    endtask

    // Present a request and return once it has been accepted; the
    // model is updated at the accept point.
    task automatic issue(input bit w, input logic [2:0] sz,
                         input logic [7:0] a, input logic [31:0] wd,
                         output bit exp_e, output logic [31:0] exp_d);
        int t;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("req_ready_wait", {31'h0, req_ready}, 32'd1);
        exp_e = m_err(w, sz, a);
        exp_d = (exp_e || w) ? 32'h0 : m_load(sz, a);
        if (w && !exp_e) m_store(sz, a, wd);
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_size  = 3'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
    endtask

    task automatic do_op(input bit w, input logic [2:0] sz,
                         input logic [7:0] a, input logic [31:0] wd,
                         input int hold);
        bit          exp_e;
        logic [31:0] exp_d;
        int          lat;
        issue(w, sz, a, wd, exp_e, exp_d);
        chk("busy_ready", {31'h0, req_ready}, 32'd0);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, LAT);
        chk("rdata", resp_rdata, exp_d);
        chk("err", {31'h0, resp_err}, {31'h0, exp_e});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'h0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, exp_d);
            chk("hold_err", {31'h0, resp_err}, {31'h0, exp_e});
            chk("hold_ready", {31'h0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("retire_valid", {31'h0, resp_valid}, 32'd0);
        chk("retire_ready", {31'h0, req_ready}, 32'd1);
    endtask

    initial begin
        bit          e;
        logic [31:0] d;
        bit          w;
        logic [2:0]  sz;
        logic [7:0]  a;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 3'b0;
        req_addr   = '0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'd0);
        chk("rst_ready", {31'h0, req_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ready", {31'h0, req_ready}, 32'd1);

        for (int i = 0; i < 64; i++) do_op(1'b1, 3'd2, 8'(i * 4), $urandom, 0);

        do_op(1'b1, 3'd2, 8'h10, 32'h11223344, 0);
        do_op(1'b0, 3'd2, 8'h10, 32'h0, 0);
        do_op(1'b1, 3'd0, 8'h13, 32'h000000AB, 0);
        do_op(1'b0, 3'd2, 8'h10, 32'h0, 0);
        do_op(1'b0, 3'd4, 8'h13, 32'h0, 0);
        do_op(1'b1, 3'd1, 8'h12, 32'h00008001, 0);
        do_op(1'b0, 3'd1, 8'h12, 32'h0, 0);
        do_op(1'b0, 3'd5, 8'h12, 32'h0, 0);
        do_op(1'b0, 3'd0, 8'h12, 32'h0, 0);
        do_op(1'b0, 3'd2, 8'h02, 32'h0, 0);
        do_op(1'b1, 3'd1, 8'h11, 32'hDEADBEEF, 0);
        do_op(1'b0, 3'd3, 8'h00, 32'h0, 0);
        do_op(1'b1, 3'd4, 8'h10, 32'hFFFFFFFF, 0);
        do_op(1'b0, 3'd2, 8'h10, 32'h0, 0);
        do_op(1'b0, 3'd2, 8'h00, 32'h0, 0);
        do_op(1'b0, 3'd2, 8'h10, 32'h0, 3);

        // Reset during WAIT of a load, then of a store.
        issue(1'b0, 3'd2, 8'h20, 32'h0, e, d);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstw_valid", {31'h0, resp_valid}, 32'd0);
        chk("rstw_ready", {31'h0, req_ready}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("rstw_stale", {31'h0, resp_valid}, 32'd0);
        end
        chk("rstw_idle", {31'h0, req_ready}, 32'd1);

        issue(1'b1, 3'd2, 8'h24, 32'hCAFEF00D, e, d);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rsts_valid", {31'h0, resp_valid}, 32'd0);
        do_op(1'b0, 3'd2, 8'h24, 32'h0, 0);

        for (int i = 0; i < 300; i++) begin
            w  = 1'($urandom);
            sz = 3'($urandom);
            a  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: sz = 3'd0;
                    1: sz = 3'd1;
                    2: sz = 3'd2;
                    3: sz = 3'd4;
                    default: sz = 3'd5;
                endcase
                if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
                if (sz == 3'd2) a[1:0] = 2'b00;
                if (sz[2]) w = 1'b0;
            end
            do_op(w, sz, a, $urandom, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

endmodule
